// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM states, opcodes,
// ALU control codes, ALU operand-B selects and the bundled control-word struct.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_R     = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_BEQ   = 2'd3
    } op_class_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       pc_source;
        logic       illegal_op;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Datapath <-> control bundle. master = the control FSM, slave = the datapath.
// Level signals only: no valid/ready pairing; mem_ready is a completion level sampled each clock.
interface multi_cycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IRWrite;
    logic       PCWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       PCSource;
    logic       illegal_op;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, PCSource, illegal_op, ALUOp, ALUSrcB, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, PCSource, illegal_op, ALUOp, ALUSrcB, state
    );
endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: maps IR[6:0] to an instruction class and
// flags anything outside the four supported classes as illegal.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CLS_R;
        illegal  = 1'b0;
        case (opcode)
            OP_R:     op_class = CLS_R;
            OP_LOAD:  op_class = CLS_LOAD;
            OP_STORE: op_class = CLS_STORE;
            OP_BEQ:   op_class = CLS_BEQ;
            default:  illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle CPU (FETCH/DECODE/EXEC/MEM/WB).
// Define MEM_HANDSHAKE_EN to make FETCH and MEM wait for mem_ready.
module multi_cycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    multi_cycle_control_if.master  bus
);

    state_t    state;
    state_t    next_state;
    op_class_t cls_q;
    op_class_t dec_cls;
    logic      dec_illegal;
    logic      mem_done;
    ctrl_t     ctrl;

    opcode_class_decode u_dec (
        .opcode   (bus.opcode),
        .op_class (dec_cls),
        .illegal  (dec_illegal)
    );

`ifdef MEM_HANDSHAKE_EN
    assign mem_done = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_done         = 1'b1;
`endif

    // The class is captured only while in DECODE, so later opcode changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            cls_q <= CLS_R;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: next_state = dec_illegal ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CLS_R:               next_state = S_WB;
                    CLS_LOAD, CLS_STORE: next_state = S_MEM;
                    default:             next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!mem_done)            next_state = S_MEM;
                else if (cls_q == CLS_LOAD) next_state = S_WB;
                else                      next_state = S_FETCH;
            end
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are gated by reset_n itself so an abort kills strobes in the same cycle.
    always_comb begin
        ctrl = '0;
        if (reset_n) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ir_write  = mem_done;
                    ctrl.pc_write  = mem_done;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = SRCB_IMM;
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.illegal_op = dec_illegal;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    case (cls_q)
                        CLS_R: begin
                            ctrl.alu_src_b = SRCB_REG;
                            ctrl.alu_op    = ALUOP_FUNCT;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            ctrl.alu_src_b = SRCB_IMM;
                            ctrl.alu_op    = ALUOP_ADD;
                        end
                        CLS_BEQ: begin
                            ctrl.alu_src_b = SRCB_REG;
                            ctrl.alu_op    = ALUOP_SUB;
                            ctrl.pc_source = 1'b1;
                            ctrl.pc_write  = bus.zero;
                        end
                        default: ctrl.alu_src_a = 1'b1;
                    endcase
                end
                S_MEM: begin
                    ctrl.mem_read  = (cls_q == CLS_LOAD);
                    ctrl.mem_write = (cls_q == CLS_STORE);
                end
                S_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = (cls_q == CLS_LOAD);
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.PCSource   = ctrl.pc_source;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.state      = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: an instruction-level model emits the expected
// per-cycle control word; a negedge checker compares it to the DUT every cycle.
module tb_multi_cycle_control;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    logic [15:0] exp_q[$];
    logic [15:0] obs;
    logic [15:0] last_exec_exp;
    logic [15:0] last_dec_exp;

    multi_cycle_control_if bus ();

    multi_cycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.state, bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite,
                  bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.PCSource,
                  bus.illegal_op, bus.ALUOp, bus.ALUSrcB};

    // ---- scoreboard ----
    always @(negedge clk) begin
        logic [15:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL cycle_word t=%0t: got %h required %h", $time, obs, e);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ---- model ----
    function automatic logic [15:0] mk(input logic [2:0] st, input logic ir, input logic pcw,
                                       input logic mr, input logic mw, input logic rw,
                                       input logic m2r, input logic sa, input logic pcs,
                                       input logic ill, input logic [1:0] aop,
                                       input logic [1:0] srcb);
        return {st, ir, pcw, mr, mw, rw, m2r, sa, pcs, ill, aop, srcb};
    endfunction

    // 0=R 1=LOAD 2=STORE 3=BEQ 4=illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 0;
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            default:    return 4;
        endcase
    endfunction

    task automatic step(input logic [15:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---- driver: one instruction, called at posedge+1 with the DUT in FETCH ----
    task automatic issue(input logic [6:0] op, input bit z, input int fw, input int mw,
                         input bit abort_mem, output int ncyc);
        int c;
        int nf;
        int nm;
        logic [15:0] e;
        c    = cls_of(op);
        ncyc = 0;
        bus.opcode = op;
        bus.zero   = ~z;
        nf = HS ? fw + 1 : 1;
        for (int i = 0; i < nf; i++) begin
            bus.mem_ready = (i >= fw);
            step(mk(3'd0, i == nf - 1, i == nf - 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01));
            ncyc++;
        end
        bus.mem_ready = 1'($urandom_range(0, 1));
        e = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, c == 4, 2'b00, 2'b10);
        last_dec_exp = e;
        step(e);
        ncyc++;
        if (c == 4) return;
        bus.opcode = op ^ 7'h7f;
        bus.zero   = z;
        case (c)
            0:       e = mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00);
            3:       e = mk(3'd2, 0, z, 0, 0, 0, 0, 1, 1, 0, 2'b01, 2'b00);
            default: e = mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10);
        endcase
        last_exec_exp = e;
        step(e);
        ncyc++;
        bus.zero = ~z;
        if (c == 3) return;
        if (c == 1 || c == 2) begin
            nm = HS ? mw + 1 : 1;
            for (int i = 0; i < nm; i++) begin
                bus.mem_ready = (i >= mw);
                e = mk(3'd3, 0, 0, c == 1, c == 2, 0, 0, 0, 0, 0, 2'b00, 2'b00);
                if (abort_mem && c == 2) begin
                    exp_q.push_back(e);
                    @(negedge clk);
                    #2;
                    reset_n = 1'b0;
                    #1;
                    check_lit("abort_memwrite_drop", int'(bus.MemWrite), 0);
                    check_lit("abort_state_fetch", int'(bus.state), 0);
                    @(posedge clk);
                    #1;
                    step(16'h0000);
                    reset_n = 1'b1;
                    bus.mem_ready = 1'b1;
                    return;
                end
                step(e);
                ncyc++;
            end
            if (c == 2) return;
        end
        step(mk(3'd4, 0, 0, 0, 0, 1, c == 1, 0, 0, 0, 2'b00, 2'b00));
        ncyc++;
    endtask

    // ---- stimulus ----
    logic [6:0] tbl_op [8] = '{7'b0110011, 7'b0000011, 7'b1100011, 7'b0100011,
                               7'b0010011, 7'b1100011, 7'b0000011, 7'b0110011};
    bit         tbl_z  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         tbl_fw [8] = '{1, 0, 2, 0, 0, 1, 2, 0};
    int         tbl_mw [8] = '{0, 1, 0, 2, 0, 0, 0, 0};

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        reset_n       = 1'b0;
        bus.opcode    = 7'b0100011;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(16'h0000);
        reset_n = 1'b1;
        bus.opcode = 7'b0110011;
        #3;
        check_lit("first_fetch_word", int'(obs), 16'h1C01);

        issue(7'b0110011, 1'b0, 0, 0, 1'b0, n);
        check_lit("r_cycles", n, 4);
        issue(7'b0000011, 1'b0, 0, 0, 1'b0, n);
        check_lit("load_cycles", n, 5);
        issue(7'b0000011, 1'b0, 0, 2, 1'b0, n);
        check_lit("load_wait_cycles", n, HS ? 7 : 5);
        issue(7'b0100011, 1'b1, 0, 0, 1'b0, n);
        check_lit("store_cycles", n, 4);
        issue(7'b1100011, 1'b1, 0, 0, 1'b0, n);
        check_lit("beq_taken_cycles", n, 3);
        check_lit("beq_taken_exec_word", int'(last_exec_exp), 16'h4864);
        issue(7'b1100011, 1'b0, 0, 0, 1'b0, n);
        check_lit("beq_not_taken_cycles", n, 3);
        check_lit("beq_not_taken_exec_word", int'(last_exec_exp), 16'h4064);
        issue(7'b1111111, 1'b0, 0, 0, 1'b0, n);
        check_lit("illegal_cycles", n, 2);
        check_lit("illegal_decode_word", int'(last_dec_exp), 16'h2012);
        issue(7'b0000000, 1'b1, 1, 0, 1'b0, n);
        issue(7'b0100011, 1'b0, 0, 1, 1'b1, n);
        issue(7'b0110011, 1'b1, 0, 0, 1'b0, n);
        check_lit("r_after_abort_cycles", n, 4);
        for (int k = 0; k < 8; k++) begin
            issue(tbl_op[k], tbl_z[k], tbl_fw[k], tbl_mw[k], 1'b0, n);
        end
        @(negedge clk);
        #1;
        check_lit("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: got no finish required finish by 200000");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous and active-low; one clock, no other clock domain.
REQ-003 SHALL have port: opcode  input  7  instruction bits [6:0] from the datapath IR.
REQ-004 SHALL have port: zero  input  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete.
REQ-006 SHALL have outputs (all 1 bit): IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA, PCSource, illegal_op.
REQ-007 SHALL have outputs: ALUOp  2  (ALU control code: 00 add, 01 sub, 10 funct-decoded); ALUSrcB  2  (00 reg, 01 const 4, 10 imm); state  3  (debug).

Function
REQ-008 SHALL implement a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unused.
REQ-009 Opcode classes: R=0110011, LOAD=0000011, STORE=0100011, BEQ=1100011; anything else is illegal.
REQ-010 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=1 only in the cycle the fetch completes; then -> DECODE.
REQ-011 DECODE: latch opcode class into an internal register; ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target).
REQ-012 From DECODE: a legal class -> EXEC; an illegal class pulses illegal_op=1 for one cycle -> FETCH.
REQ-013 EXEC for R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB.
REQ-014 EXEC for LOAD or STORE: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM.
REQ-015 EXEC for BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1; PCWrite=zero (same cycle, combinational) -> FETCH.
REQ-016 MEM for LOAD: MemRead=1, -> WB on completion.
REQ-017 MEM for STORE: MemWrite=1, -> FETCH on completion.
REQ-018 WB: RegWrite=1; MemtoReg=1 for LOAD, 0 for R -> FETCH.
REQ-019 Every output not listed for a state SHALL be 0.
REQ-020 opcode SHALL be sampled only in DECODE; opcode changes in later states have no effect.
REQ-021 Cycle counts with zero-wait memory: R=4, LOAD=5, STORE=4, BEQ=3, illegal=2.
REQ-022 An unused state code SHALL drive all strobes 0 and go to FETCH on the next edge.

Reset
REQ-023 While reset_n=0: state=FETCH, latched class=R, and all 1-bit outputs, ALUOp and ALUSrcB forced to 0.
REQ-024 reset_n asserted mid-instruction SHALL abort it immediately, with no partial MemWrite or RegWrite after assertion.
REQ-025 The first rising edge after reset_n rises SHALL be a FETCH cycle with FETCH outputs.

Configuration
REQ-026 Macro MEM_HANDSHAKE_EN defined: "completion" in FETCH and MEM means mem_ready=1; the FSM holds state (outputs steady, IRWrite=PCWrite=0) while mem_ready=0.
REQ-027 MEM_HANDSHAKE_EN undefined: mem_ready is ignored and FETCH and MEM each complete in exactly one cycle.

Structure
REQ-028 A shared package cpu_ctrl_pkg SHALL hold the state encodings, opcode constants, ALUOp encodings (ALUOP_ADD/SUB/FUNCT) and ALUSrcB encodings.
REQ-029 Sub-module opcode_class_decode (combinational: opcode -> class, illegal) SHALL be instantiated once; next-state and output logic stay in multi_cycle_control.

Verification
REQ-030 Reset test: reset_n=0 for 3 cycles, then release -> all strobes 0 during reset; cycle 1 after release has state=0, MemRead=1, ALUSrcB=01.
REQ-031 R-type test: opcode=0110011, mem_ready=1 -> states 0,1,2,4,0; ALUOp=10 in EXEC; RegWrite=1, MemtoReg=0 in WB.
REQ-032 LOAD test with handshake: opcode=0000011, MEM_HANDSHAKE_EN defined, mem_ready low 2 cycles in MEM -> MEM held 3 cycles with MemRead=1, then WB with MemtoReg=1.
REQ-033 BEQ test: opcode=1100011 with zero=1, then with zero=0 -> EXEC shows ALUOp=01, PCSource=1, PCWrite=1 vs 0; 3 cycles each.
REQ-034 Illegal test: opcode=1111111 -> illegal_op=1 for exactly one cycle after DECODE, then state=0, no RegWrite or MemWrite.
REQ-035 Abort test: reset_n pulsed low during STORE MEM -> MemWrite drops the same cycle; next instruction starts in FETCH.
